// File: rtl/data_receiver.sv
// Serial-to-parallel receiver for the three-wire transmission/clock/data link.
// Synchronises the link into clk, shifts WIDTH bits MSB first, strobes ready or error.
module data_receiver #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             transmission,
  input  logic             clock,
  input  logic             data,
  output logic [WIDTH-1:0] out,
  output logic             ready,
  output logic             busy,
  output logic             error
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT);
  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES + 1);

  typedef enum logic {
    IDLE,
    RECEIVE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] tx_sync_q, tx_sync_d;
  logic [SYNC_STAGES-1:0] ck_sync_q, ck_sync_d;
  logic [SYNC_STAGES-1:0] dt_sync_q, dt_sync_d;
  logic                   tx_dly_q, tx_dly_d;
  logic                   ck_dly_q, ck_dly_d;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             armed_q, armed_d;
  logic             fall_q, fall_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  logic tx_s, ck_s, dt_s;
  logic tx_rise, tx_fall, ck_rise;

  always_comb begin
    tx_sync_d = {tx_sync_q[SYNC_STAGES-2:0], transmission};
    ck_sync_d = {ck_sync_q[SYNC_STAGES-2:0], clock};
    dt_sync_d = {dt_sync_q[SYNC_STAGES-2:0], data};
    tx_s      = tx_sync_q[SYNC_STAGES-1];
    ck_s      = ck_sync_q[SYNC_STAGES-1];
    dt_s      = dt_sync_q[SYNC_STAGES-1];
    tx_dly_d  = tx_s;
    ck_dly_d  = ck_s;

    // A frame only starts on a low-to-high seen after reset, never on a line already high.
    tx_rise = tx_s & ~tx_dly_q & armed_q;
    tx_fall = ~tx_s & tx_dly_q;
    ck_rise = ck_s & ~ck_dly_q;

    fill_d  = fill_q;
    if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    armed_d = armed_q | ((fill_q == FILL_MAX) & ~tx_s & ~tx_dly_q);

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    out_d   = out_q;
    fall_d  = 1'b0;
    ready_d = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_rise) begin
          state_d = RECEIVE;
          shift_d = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      RECEIVE: begin
        fall_d = tx_fall;
        tmo_d  = tmo_q + 1'b1;
        if (ck_rise) begin
          shift_d = {shift_q[WIDTH-2:0], dt_s};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          tmo_d = '0;
        end
        // Frame end is judged a cycle after the fall so a coincident bit is counted.
        if (fall_q) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            out_d   = shift_q;
            ready_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end else if (!tx_fall && tmo_d == TMO_END) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_sync_q <= '0;
      ck_sync_q <= '0;
      dt_sync_q <= '0;
      tx_dly_q  <= 1'b0;
      ck_dly_q  <= 1'b0;
      shift_q   <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      fall_q    <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sync_q <= tx_sync_d;
      ck_sync_q <= ck_sync_d;
      dt_sync_q <= dt_sync_d;
      tx_dly_q  <= tx_dly_d;
      ck_dly_q  <= ck_dly_d;
      shift_q   <= shift_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      fall_q    <= fall_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;
  assign error = error_q;
  assign busy  = (state_q == RECEIVE);

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: scoreboard of expected strobes,
// popped and checked whenever ready or error fires.
module tb_data_receiver;

  localparam int SYNC = 2;
  localparam int TMO  = 1000;
  localparam int HP   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        transmission;
  logic        clock;
  logic        data;
  logic [63:0] out;
  logic        ready;
  logic        busy;
  logic        error;

  data_receiver #(
    .WIDTH(64),
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .transmission(transmission),
    .clock(clock),
    .data(data),
    .out(out),
    .ready(ready),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] word;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  int          strobe_cyc = 0;
  logic [63:0] good = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (ready === 1'b1 || error === 1'b1)) begin
      strobe_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_strobe", {62'd0, ready, error}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ready", {63'd0, ready}, {63'd0, ~e.err});
        chk("error", {63'd0, error}, {63'd0, e.err});
        chk("out", out, e.word);
      end
    end
  end

  // mode 0: full frame with fall, 1: no fall, 2: fall with final clock rise
  task automatic send(input logic [63:0] w, input int n, input int mode);
    transmission = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("busy_pre", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("busy_rise", {63'd0, busy}, 64'd1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      data = (n - 1 - i < 64) ? w[n-1-i] : 1'b0;
      repeat (HP) @(negedge clk);
      clock = 1'b1;
      rise_cyc = cyc;
      if (mode == 2 && i == n - 1) begin
        transmission = 1'b0;
        fall_cyc = cyc;
      end
      repeat (HP) @(negedge clk);
      clock = 1'b0;
      if (i == n / 2) chk("busy_mid", {63'd0, busy}, 64'd1);
    end
    if (mode == 0) begin
      repeat (HP) @(negedge clk);
      transmission = 1'b0;
      fall_cyc = cyc;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && q.size() != 0; k++) @(posedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $error("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    transmission = 1'b0;
    clock = 1'b0;
    data = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // reset in the middle of a frame, line still high on release
    send(64'hDEADBEEF_CAFEF00D, 20, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_out", out, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    transmission = 1'b0;
    repeat (5) @(negedge clk);
    good = 64'hDEADBEEF_CAFEF00D;
    q.push_back('{err: 1'b0, word: good});
    send(good, 64, 0);
    drain();
    chk("busy_end", {63'd0, busy}, 64'd0);

    // nominal frame and strobe latency
    good = 64'h0123456789ABCDEF;
    q.push_back('{err: 1'b0, word: good});
    send(good, 64, 0);
    drain();
    chk("ready_lat", 64'(strobe_cyc - fall_cyc), 64'(SYNC + 2));

    // short and long frames leave out unchanged
    q.push_back('{err: 1'b1, word: good});
    send(64'h5555AAAA5555AAAA, 63, 0);
    drain();
    chk("error_lat", 64'(strobe_cyc - fall_cyc), 64'(SYNC + 2));
    q.push_back('{err: 1'b1, word: good});
    send(64'h3333CCCC3333CCCC, 65, 0);
    drain();

    // timeout with clock held low
    q.push_back('{err: 1'b1, word: good});
    send(64'hFFFF0000FFFF0000, 10, 1);
    repeat (TMO + 5) @(negedge clk);
    chk("tmo_busy", {63'd0, busy}, 64'd0);
    chk("tmo_seen", 64'(q.size()), 64'd0);
    chk("tmo_win", {63'd0, (strobe_cyc - rise_cyc >= TMO) &&
                           (strobe_cyc - rise_cyc <= TMO + SYNC + 3)}, 64'd1);
    transmission = 1'b0;
    repeat (10) @(negedge clk);
    chk("tmo_no_extra", 64'(q.size()), 64'd0);

    // back-to-back with minimum gap
    q.push_back('{err: 1'b0, word: 64'hFFFFFFFFFFFFFFFF});
    q.push_back('{err: 1'b0, word: 64'h0000000000000001});
    send(64'hFFFFFFFFFFFFFFFF, 64, 0);
    repeat (SYNC + 1) @(negedge clk);
    send(64'h0000000000000001, 64, 0);
    drain();
    good = 64'h0000000000000001;

    // final clock rise and frame end synchronised together
    repeat (SYNC + 3) @(negedge clk);
    good = 64'hA5C3_0F1E_9687_B4D2;
    q.push_back('{err: 1'b0, word: good});
    send(good, 64, 2);
    repeat (HP) @(negedge clk);
    drain();
    chk("edge_busy", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
